// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: HI/LO registers, operand latch and a
// fixed-latency busy window for multi-cycle operations.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no operation in flight; accepts mult/div/madd/msub/mthi/mtlo
// BUSY  | operation in flight; cnt counts down, commit when cnt reaches 1
module mdu_ctrl #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic        d_md_use,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MSUB  = 4'd8;

  localparam logic [3:0] MULT_CNT = 4'(MULT_LAT);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_LAT);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [3:0]  op_q, op_nxt;
  logic [31:0] a_q, a_nxt;
  logic [31:0] b_q, b_nxt;
  logic [31:0] hi_nxt, lo_nxt;

  logic        is_long;
  logic [63:0] a_sx, b_sx, a_zx, b_zx;
  logic [63:0] prod_s, prod_u, acc, madd_res, msub_res;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, q_s, r_s, q_u, r_u;

  // Ops that occupy the unit for a latency window.
  always_comb begin
    is_long = 1'b0;
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MADD, OP_MSUB: is_long = 1'b1;
      default: is_long = 1'b0;
    endcase
  end

  // Datapath from latched operands; low 64 bits of a 64x64 product of
  // sign-extended inputs equal the signed 32x32 product.
  always_comb begin
    a_sx     = {{32{a_q[31]}}, a_q};
    b_sx     = {{32{b_q[31]}}, b_q};
    a_zx     = {32'd0, a_q};
    b_zx     = {32'd0, b_q};
    prod_s   = a_sx * b_sx;
    prod_u   = a_zx * b_zx;
    acc      = {hi, lo};
    madd_res = acc + prod_s;
    msub_res = acc - prod_s;
  end

  // Signed division via magnitudes: avoids the INT_MIN / -1 overflow case
  // and gives truncation toward zero with remainder sign of the dividend.
  always_comb begin
    a_neg = a_q[31];
    b_neg = b_q[31];
    a_mag = a_neg ? (32'd0 - a_q) : a_q;
    b_mag = b_neg ? (32'd0 - b_q) : b_q;
    q_mag = 32'd0;
    r_mag = 32'd0;
    q_u   = 32'd0;
    r_u   = 32'd0;
    if (b_q != 32'd0) begin
      q_mag = a_mag / b_mag;
      r_mag = a_mag % b_mag;
      q_u   = a_q / b_q;
      r_u   = a_q % b_q;
    end
    q_s = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    r_s = a_neg ? (32'd0 - r_mag) : r_mag;
  end

  // Next-state, counter, operand latch and HI/LO update.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    op_nxt    = op_q;
    a_nxt     = a_q;
    b_nxt     = b_q;
    hi_nxt    = hi;
    lo_nxt    = lo;
    case (state)
      IDLE: begin
        if (start) begin
          if (is_long) begin
            op_nxt    = op;
            a_nxt     = rs;
            b_nxt     = rt;
            cnt_nxt   = (op == OP_DIV || op == OP_DIVU) ? DIV_CNT : MULT_CNT;
            state_nxt = BUSY;
          end else if (op == OP_MTHI) begin
            hi_nxt = rs;
          end else if (op == OP_MTLO) begin
            lo_nxt = rs;
          end
        end
      end
      BUSY: begin
        if (cnt <= 4'd1) begin
          state_nxt = IDLE;
          cnt_nxt   = 4'd0;
          case (op_q)
            OP_MULT:  {hi_nxt, lo_nxt} = prod_s;
            OP_MULTU: {hi_nxt, lo_nxt} = prod_u;
            OP_MADD:  {hi_nxt, lo_nxt} = madd_res;
            OP_MSUB:  {hi_nxt, lo_nxt} = msub_res;
            OP_DIV: begin
              if (b_q != 32'd0) begin
                hi_nxt = r_s;
                lo_nxt = q_s;
              end
            end
            OP_DIVU: begin
              if (b_q != 32'd0) begin
                hi_nxt = r_u;
                lo_nxt = q_u;
              end
            end
            default: ;
          endcase
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and data registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
      op_q  <= 4'd0;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      hi    <= 32'd0;
      lo    <= 32'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      op_q  <= op_nxt;
      a_q   <= a_nxt;
      b_q   <= b_nxt;
      hi    <= hi_nxt;
      lo    <= lo_nxt;
    end
  end

  assign busy = (state == BUSY);

  // Busy term masked during reset since the in-flight op is being dropped.
  assign stall_req = d_md_use & ((busy & ~reset) | (start & is_long));

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed self-checking bench for mdu_ctrl with default latencies.
module tb_mdu_ctrl;

  localparam int ML = 5;
  localparam int DL = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] rs, rt;
  logic        d_md_use;
  logic        busy, stall_req;
  logic [31:0] hi, lo;

  int checks   = 0;
  int failures = 0;

  mdu_ctrl #(.MULT_LAT(ML), .DIV_LAT(DL)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .rs(rs), .rt(rt),
    .d_md_use(d_md_use), .busy(busy), .stall_req(stall_req), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a start for one cycle, then return in the following cycle.
  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; rs = a; rt = b;
    step();
    start = 1'b0; op = 4'd0;
  endtask

  // Expect busy for n cycles (already in the first busy cycle), end in cycle T+n+1.
  task automatic busy_window(input string tag, input int n);
    for (int i = 1; i <= n; i++) begin
      check({tag, "_busy"}, 64'(busy), 64'd1);
      step();
    end
    check({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  task automatic check_hilo(input string tag, input logic [31:0] eh, input logic [31:0] el);
    check({tag, "_hilo"}, {hi, lo}, {eh, el});
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 4'd0; rs = '0; rt = '0; d_md_use = 1'b1;
    step();
    check("rst_stall", 64'(stall_req), 64'd0);
    step();
    check("rst_busy", 64'(busy), 64'd0);
    check_hilo("rst", 32'h0, 32'h0);
    reset = 1'b0; d_md_use = 1'b0;

    // Scenario 1: signed mult
    issue(4'd1, 32'hFFFFFFFE, 32'd3);
    for (int i = 1; i < ML; i++) step();
    check("s1_busy_last", 64'(busy), 64'd1);
    check_hilo("s1_precommit", 32'h0, 32'h0);
    step();
    check("s1_idle", 64'(busy), 64'd0);
    check_hilo("s1", 32'hFFFFFFFF, 32'hFFFFFFFA);

    // Scenario 2: unsigned mult, issued back-to-back in the cycle busy fell
    issue(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
    busy_window("s2", ML);
    check_hilo("s2", 32'hFFFFFFFE, 32'h00000001);

    // Scenario 3: signed division
    issue(4'd3, 32'hFFFFFFF9, 32'd2);
    busy_window("s3a", DL);
    check_hilo("s3a", 32'hFFFFFFFF, 32'hFFFFFFFD);
    issue(4'd3, 32'h80000000, 32'hFFFFFFFF);
    busy_window("s3b", DL);
    check_hilo("s3b", 32'h0, 32'h80000000);
    issue(4'd4, 32'd100, 32'd7);
    busy_window("divu", DL);
    check_hilo("divu", 32'd2, 32'd14);

    // Scenario 4: preload, then divide by zero
    issue(4'd5, 32'd5, 32'd0);
    check("mthi_busy", 64'(busy), 64'd0);
    issue(4'd6, 32'd7, 32'd0);
    check_hilo("s4_preload", 32'd5, 32'd7);
    issue(4'd4, 32'd9, 32'd0);
    busy_window("s4", DL);
    check_hilo("s4", 32'd5, 32'd7);

    // Undefined ops are ignored
    issue(4'd9, 32'h1234, 32'h5678);
    check("op9_busy", 64'(busy), 64'd0);
    check_hilo("op9", 32'd5, 32'd7);
    issue(4'd0, 32'h1234, 32'h5678);
    check_hilo("op0", 32'd5, 32'd7);

    // Scenario 5: stall through a mult; mtlo during busy ignored
    d_md_use = 1'b1;
    start = 1'b1; op = 4'd1; rs = 32'd2; rt = 32'd3;
    #1 check("s5_stall_start", 64'(stall_req), 64'd1);
    step();
    start = 1'b0; op = 4'd0;
    for (int i = 1; i <= ML; i++) begin
      check("s5_stall_busy", 64'(stall_req), 64'd1);
      check("s5_busy", 64'(busy), 64'd1);
      if (i == 2) begin
        start = 1'b1; op = 4'd6; rs = 32'hDEADBEEF;
      end else begin
        start = 1'b0; op = 4'd0;
      end
      step();
    end
    check("s5_stall_after", 64'(stall_req), 64'd0);
    check("s5_idle", 64'(busy), 64'd0);
    check_hilo("s5", 32'd0, 32'd6);
    d_md_use = 1'b0;

    // Scenario 6: madd interrupted by reset
    issue(4'd5, 32'd0, 32'd0);
    issue(4'd6, 32'hFFFFFFFF, 32'd0);
    issue(4'd7, 32'd2, 32'd3);
    step(); step();
    check("s6_busy3", 64'(busy), 64'd1);
    reset = 1'b1; d_md_use = 1'b1;
    #1 check("s6_rst_stall", 64'(stall_req), 64'd0);
    step();
    reset = 1'b0; d_md_use = 1'b0;
    check("s6_rst_busy", 64'(busy), 64'd0);
    check_hilo("s6_rst", 32'h0, 32'h0);
    for (int i = 0; i < ML + 1; i++) step();
    check_hilo("s6_nocommit", 32'h0, 32'h0);

    issue(4'd5, 32'd0, 32'd0);
    issue(4'd6, 32'hFFFFFFFF, 32'd0);
    issue(4'd7, 32'd2, 32'd3);
    busy_window("s6", ML);
    check_hilo("s6", 32'h00000001, 32'h00000005);

    // Back-to-back msub with a negative product: {1,5} - (-2*3) = {1,0xB}
    issue(4'd8, 32'hFFFFFFFE, 32'd3);
    busy_window("msub", ML);
    check_hilo("msub", 32'h00000001, 32'h0000000B);

    // Reset overrides a simultaneous start
    reset = 1'b1; start = 1'b1; op = 4'd1; rs = 32'd4; rt = 32'd4;
    step();
    reset = 1'b0; start = 1'b0; op = 4'd0;
    check("rst_start_busy", 64'(busy), 64'd0);
    check_hilo("rst_start", 32'h0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
